nine_segment_animator: RTL

Frame sequencer for the 3x3 LED display. It stores up to DEPTH 9-bit segment patterns written by a host over a valid/ready port. On command it plays them back, holding each pattern for a programmable number of clocks, in one-shot or loop mode. Its `segments` output feeds the row/column scan driver directly, so the scan driver only ever sees one stable pattern at a time.

---
 rtl/nine_segment_pkg.sv | 12 +
 rtl/nine_segment_frame_store.sv | 26 ++
 rtl/nine_segment_animator.sv | 139 +++++++++++++
 3 files changed

// File: rtl/nine_segment_pkg.sv
// Shared types and constants for the 3x3 LED frame sequencer.
package nine_segment_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } anim_state_t;

  localparam int SEG_W = 9;
  localparam logic [SEG_W-1:0] SEG_BLANK = 9'b0;

endpackage

// File: rtl/nine_segment_frame_store.sv
// Frame pattern memory: one synchronous write port, one combinational read port.
module nine_segment_frame_store
  import nine_segment_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [SEG_W-1:0]           wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [SEG_W-1:0]           rdata
);

  logic [SEG_W-1:0] mem [DEPTH];

  // Contents are only meaningful below frame_count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/nine_segment_animator.sv
// Frame sequencer: stores host-written patterns and plays them back with a
// programmable per-frame hold, one-shot or looping.
module nine_segment_animator
  import nine_segment_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int HOLD_W = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_valid,
  input  logic [SEG_W-1:0]             wr_data,
  output logic                         wr_ready,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         clear,
  input  logic                         loop,
  input  logic [HOLD_W-1:0]            hold_cycles,
  output logic [SEG_W-1:0]             segments,
  output logic [$clog2(DEPTH)-1:0]     frame_idx,
  output logic [$clog2(DEPTH+1)-1:0]   frame_count,
  output logic                         busy,
  output logic                         done
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  anim_state_t       state, state_n;
  logic [IDX_W-1:0]  idx_n, rd_addr;
  logic [CNT_W-1:0]  count_n;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_n, hold_len, hold_len_n, hold_eff;
  logic              loop_q, loop_n;
  logic [SEG_W-1:0]  seg_n, rd_data;
  logic              busy_n, done_n, wr_en, last_frame;

  assign wr_ready   = (state == IDLE) && (frame_count < CNT_W'(DEPTH)) && !start;
  assign wr_en      = wr_valid && wr_ready && !clear && !reset;
  assign hold_eff   = (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
  assign last_frame = (CNT_W'(frame_idx) + CNT_W'(1)) == frame_count;

  // The read port always looks at the frame that would be shown next.
  assign rd_addr = (state == PLAY && !last_frame) ? frame_idx + IDX_W'(1) : '0;

  nine_segment_frame_store #(
    .DEPTH(DEPTH)
  ) u_store (
    .clk   (clk),
    .we    (wr_en),
    .waddr (frame_count[IDX_W-1:0]),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_comb begin
    state_n    = state;
    idx_n      = frame_idx;
    count_n    = frame_count;
    hold_cnt_n = hold_cnt;
    hold_len_n = hold_len;
    loop_n     = loop_q;
    seg_n      = segments;
    busy_n     = busy;
    done_n     = 1'b0;

    if (clear) begin
      state_n = IDLE;
      idx_n   = '0;
      count_n = '0;
      seg_n   = SEG_BLANK;
      busy_n  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          seg_n  = SEG_BLANK;
          busy_n = 1'b0;
          if (!stop && start && frame_count != '0) begin
            state_n    = PLAY;
            idx_n      = '0;
            hold_len_n = hold_eff;
            hold_cnt_n = hold_eff;
            loop_n     = loop;
            seg_n      = rd_data;
            busy_n     = 1'b1;
          end else if (wr_en) begin
            count_n = frame_count + CNT_W'(1);
          end
        end
        PLAY: begin
          if (stop) begin
            state_n = IDLE;
            seg_n   = SEG_BLANK;
            busy_n  = 1'b0;
          end else if (hold_cnt == HOLD_W'(1)) begin
            if (!last_frame || loop_q) begin
              idx_n      = rd_addr;
              hold_cnt_n = hold_len;
              seg_n      = rd_data;
            end else begin
              state_n = IDLE;
              seg_n   = SEG_BLANK;
              busy_n  = 1'b0;
              done_n  = 1'b1;
            end
          end else begin
            hold_cnt_n = hold_cnt - HOLD_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      frame_idx   <= '0;
      frame_count <= '0;
      hold_cnt    <= '0;
      hold_len    <= HOLD_W'(1);
      loop_q      <= 1'b0;
      segments    <= SEG_BLANK;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      frame_idx   <= idx_n;
      frame_count <= count_n;
      hold_cnt    <= hold_cnt_n;
      hold_len    <= hold_len_n;
      loop_q      <= loop_n;
      segments    <= seg_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

endmodule
